// File: rtl/sha512_seq_ctrl.sv
// Sequencer that assembles 16x64-bit padded message words into 1024-bit blocks
// and hands each one to a SHA-512 core with init/next pulses, then captures the digest.
module sha512_seq_ctrl (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [1:0]    mode_i,
  input  logic          word_valid_i,
  output logic          word_ready_o,
  input  logic [63:0]   word_data_i,
  input  logic          word_last_i,
  input  logic          abort_i,
  input  logic          lock_i,
  output logic          core_init_o,
  output logic          core_next_o,
  output logic [1:0]    core_mode_o,
  output logic [1023:0] core_block_o,
  input  logic          core_ready_i,
  input  logic [511:0]  core_digest_i,
  output logic [511:0]  digest_o,
  output logic          digest_valid_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [15:0]   blk_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [1023:0]   blk_q, blk_d;
  logic [3:0]      k_q, k_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [1:0]      mode_q, mode_d;
  logic [511:0]    digest_q, digest_d;
  logic            dvalid_q, dvalid_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            fire_init, fire_next;
  logic            accept;

  assign word_ready_o   = rst_ni && !lock_i && (state_q == IDLE || state_q == LOAD);
  assign accept         = word_valid_i && word_ready_o && !abort_i;
  assign core_init_o    = fire_init;
  assign core_next_o    = fire_next;
  assign core_mode_o    = mode_q;
  assign core_block_o   = blk_q;
  assign digest_o       = lock_i ? '0 : digest_q;
  assign digest_valid_o = dvalid_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign blk_cnt_o      = cnt_q;

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    k_d       = k_q;
    first_d   = first_q;
    last_d    = last_q;
    mode_d    = mode_q;
    digest_d  = digest_q;
    dvalid_d  = dvalid_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    fire_init = 1'b0;
    fire_next = 1'b0;
    // Abort wins over every transition and suppresses any pulse this cycle.
    if (abort_i) begin
      state_d  = IDLE;
      k_d      = 4'd0;
      first_d  = 1'b0;
      last_d   = 1'b0;
      dvalid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            blk_d[63:0] = word_data_i;
            mode_d      = mode_i;
            first_d     = 1'b1;
            err_d       = word_last_i;
            dvalid_d    = 1'b0;
            cnt_d       = 16'd0;
            if (!word_last_i) begin
              k_d     = 4'd1;
              state_d = LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            blk_d[{k_q, 6'd0} +: 64] = word_data_i;
            k_d = k_q + 4'd1;
            if (k_q == 4'd15) begin
              last_d  = word_last_i;
              state_d = ISSUE;
            end else if (word_last_i) begin
              err_d   = 1'b1;
              k_d     = 4'd0;
              state_d = IDLE;
            end
          end
        end
        ISSUE: begin
          if (core_ready_i) begin
            fire_init = first_q;
            fire_next = !first_q;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!core_ready_i) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_ready_i) begin
            if (last_q) begin
              digest_d = core_digest_i;
              dvalid_d = 1'b1;
              state_d  = IDLE;
            end else begin
              first_d  = 1'b0;
              k_d      = 4'd0;
              state_d  = LOAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      blk_q    <= '0;
      k_q      <= 4'd0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      mode_q   <= 2'd0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      k_q      <= k_d;
      first_q  <= first_d;
      last_q   <= last_d;
      mode_q   <= mode_d;
      digest_q <= digest_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sha512_seq_ctrl.sv
// Directed bench for sha512_seq_ctrl: expected core pulses are queued as blocks are
// driven and matched against pulses observed by a monitor.
module tb_sha512_seq_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [1:0]    mode_i;
  logic          word_valid_i;
  logic          word_ready_o;
  logic [63:0]   word_data_i;
  logic          word_last_i;
  logic          abort_i;
  logic          lock_i;
  logic          core_init_o;
  logic          core_next_o;
  logic [1:0]    core_mode_o;
  logic [1023:0] core_block_o;
  logic          core_ready_i;
  logic [511:0]  core_digest_i;
  logic [511:0]  digest_o;
  logic          digest_valid_o;
  logic          busy_o;
  logic          err_o;
  logic [15:0]   blk_cnt_o;

  sha512_seq_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .word_data_i(word_data_i), .word_last_i(word_last_i),
    .abort_i(abort_i), .lock_i(lock_i),
    .core_init_o(core_init_o), .core_next_o(core_next_o),
    .core_mode_o(core_mode_o), .core_block_o(core_block_o),
    .core_ready_i(core_ready_i), .core_digest_i(core_digest_i),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o),
    .busy_o(busy_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        init;
    logic        nxt;
    logic [63:0] w0;
    logic [63:0] w15;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [511:0] D1 = {8{64'hD1D1_0000_1111_2222}};
  localparam logic [511:0] D2 = {8{64'hD2D2_3333_4444_5555}};
  localparam logic [511:0] D3 = {8{64'hD3D3_6666_7777_8888}};
  localparam logic [511:0] D4 = {8{64'hD4D4_9999_AAAA_BBBB}};

  always @(negedge clk_i)
    if (core_init_o || core_next_o)
      obs_q.push_back({core_init_o, core_next_o, core_block_o[63:0], core_block_o[1023:960]});

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last);
    bit ok = 0;
    word_valid_i = 1'b1; word_data_i = d; word_last_i = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (word_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 512'(0), 512'(1));
    tick();
    word_valid_i = 1'b0; word_last_i = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] base, input logic last, input logic is_init);
    exp_q.push_back({is_init, !is_init, base, base + 64'd15});
    for (int k = 0; k < 16; k++) send_word(base + 64'(k), last && (k == 15));
  endtask

  // Called in the ISSUE cycle with the pulse visible; emulates a core operation.
  task automatic run_core(input int busy, input logic [511:0] dig);
    tick();
    core_ready_i = 1'b0;
    tick();
    chk("ready_in_wait", 512'(word_ready_o), 512'(0));
    repeat (busy - 1) tick();
    core_digest_i = dig;
    core_ready_i = 1'b1;
    tick();
  endtask

  task automatic check_pulses(input string tag);
    pulse_t e, o;
    chk({tag, "_pulse_count"}, 512'(obs_q.size()), 512'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_pulse"}, 512'(o), 512'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0; mode_i = 2'd0; word_valid_i = 1'b0; word_data_i = '0;
    word_last_i = 1'b0; abort_i = 1'b0; lock_i = 1'b0;
    core_ready_i = 1'b1; core_digest_i = '0;
    repeat (2) tick();
    chk("rst_ready", 512'(word_ready_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_dvalid", 512'(digest_valid_o), 512'(0));
    chk("rst_cnt", 512'(blk_cnt_o), 512'(0));
    chk("rst_err", 512'(err_o), 512'(0));
    rst_ni = 1'b1; #1;
    chk("post_rst_ready", 512'(word_ready_o), 512'(1));

    // Single block message
    mode_i = 2'd2;
    send_block(64'h0, 1'b1, 1'b1);
    chk("single_init_T1", 512'(core_init_o), 512'(1));
    chk("single_next_T1", 512'(core_next_o), 512'(0));
    chk("single_w0", 512'(core_block_o[63:0]), 512'(0));
    chk("single_w15", 512'(core_block_o[1023:960]), 512'(64'hF));
    chk("single_ready_issue", 512'(word_ready_o), 512'(0));
    chk("single_mode", 512'(core_mode_o), 512'(2));
    run_core(3, D1);
    chk("single_dvalid", 512'(digest_valid_o), 512'(1));
    chk("single_digest", digest_o, D1);
    chk("single_cnt", 512'(blk_cnt_o), 512'(1));
    chk("single_busy", 512'(busy_o), 512'(0));
    check_pulses("single");

    // Lock masks digest and blocks loads
    lock_i = 1'b1; #1;
    chk("lock_digest", digest_o, 512'(0));
    chk("lock_dvalid", 512'(digest_valid_o), 512'(1));
    chk("lock_ready", 512'(word_ready_o), 512'(0));
    lock_i = 1'b0; #1;
    chk("unlock_digest", digest_o, D1);

    // Three-block message
    mode_i = 2'd1;
    send_block(64'h100, 1'b0, 1'b1);
    run_core(2, D1);
    chk("three_dvalid_mid", 512'(digest_valid_o), 512'(0));
    chk("three_cnt_mid", 512'(blk_cnt_o), 512'(1));
    chk("three_ready_load", 512'(word_ready_o), 512'(1));
    send_block(64'h200, 1'b0, 1'b0);
    chk("three_next_T1", 512'(core_next_o), 512'(1));
    run_core(2, D1);
    send_block(64'h300, 1'b1, 1'b0);
    run_core(4, D2);
    chk("three_cnt", 512'(blk_cnt_o), 512'(3));
    chk("three_dvalid", 512'(digest_valid_o), 512'(1));
    chk("three_digest", digest_o, D2);
    chk("three_mode", 512'(core_mode_o), 512'(1));
    check_pulses("three");

    // Framing error: last on word 7
    for (int k = 0; k < 8; k++) send_word(64'h40 + 64'(k), k == 7);
    chk("frame_err", 512'(err_o), 512'(1));
    chk("frame_busy", 512'(busy_o), 512'(0));
    chk("frame_dvalid", 512'(digest_valid_o), 512'(0));
    check_pulses("frame");

    // Next message clears err; core held busy on ISSUE entry
    mode_i = 2'd3;
    exp_q.push_back({1'b1, 1'b0, 64'h500, 64'h50F});
    send_word(64'h500, 1'b0);
    chk("frame_err_clear", 512'(err_o), 512'(0));
    for (int k = 1; k < 15; k++) send_word(64'h500 + 64'(k), 1'b0);
    core_ready_i = 1'b0;
    send_word(64'h50F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_pulse", 512'({core_init_o, core_next_o}), 512'(0));
      tick();
    end
    core_ready_i = 1'b1; #1;
    chk("stall_init", 512'(core_init_o), 512'(1));
    run_core(1, D3);
    chk("stall_dvalid", 512'(digest_valid_o), 512'(1));
    chk("stall_digest", digest_o, D3);
    check_pulses("stall");

    // Abort in WAIT_DONE
    mode_i = 2'd2;
    send_block(64'h600, 1'b1, 1'b1);
    tick();
    core_ready_i = 1'b0;
    tick(); tick();
    chk("abort_busy_before", 512'(busy_o), 512'(1));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_idle", 512'(busy_o), 512'(0));
    chk("abort_dvalid", 512'(digest_valid_o), 512'(0));
    chk("abort_mode", 512'(core_mode_o), 512'(2));
    core_ready_i = 1'b1;
    tick();
    chk("abort_dvalid_late", 512'(digest_valid_o), 512'(0));
    check_pulses("abort");

    // Word presented together with abort is discarded
    word_valid_i = 1'b1; word_data_i = 64'hBAD; abort_i = 1'b1;
    tick();
    word_valid_i = 1'b0; abort_i = 1'b0;
    chk("abort_word_busy", 512'(busy_o), 512'(0));
    chk("abort_word_w0", 512'(core_block_o[63:0]), 512'(64'h600));

    // Reset mid-LOAD
    mode_i = 2'd3;
    for (int k = 0; k < 10; k++) send_word(64'h700 + 64'(k), 1'b0);
    rst_ni = 1'b0; #1;
    chk("mid_rst_busy", 512'(busy_o), 512'(0));
    chk("mid_rst_ready", 512'(word_ready_o), 512'(0));
    chk("mid_rst_blk_lo", core_block_o[511:0], 512'(0));
    chk("mid_rst_blk_hi", core_block_o[1023:512], 512'(0));
    chk("mid_rst_mode", 512'(core_mode_o), 512'(0));
    chk("mid_rst_digest", digest_o, 512'(0));
    chk("mid_rst_pulses", 512'({core_init_o, core_next_o}), 512'(0));
    tick();
    rst_ni = 1'b1; #1;
    mode_i = 2'd1;
    send_block(64'h800, 1'b1, 1'b1);
    chk("post_rst_init", 512'(core_init_o), 512'(1));
    chk("post_rst_next", 512'(core_next_o), 512'(0));
    run_core(1, D4);
    chk("post_rst_dvalid", 512'(digest_valid_o), 512'(1));
    chk("post_rst_digest", digest_o, D4);
    chk("post_rst_cnt", 512'(blk_cnt_o), 512'(1));
    check_pulses("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
